// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 32;

  // Transaction sequencer: grant/issue, memory access, completion.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COMPLETE = 2'd2
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first requester at or after rr_ptr+1
// (wrapping modulo NUM_REQ) that has its request bit set wins.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               any_req_o,
  output logic [IDX_W-1:0]   winner_o
);

  logic found;
  int   cand;

  // Scan upward from the slot after the last winner; the earliest hit is kept.
  always_comb begin
    any_req_o = |req_i;
    winner_o  = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr_i) + k) % NUM_REQ;
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        winner_o = cand[IDX_W-1:0];
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between
// NUM_REQ requesters. Each granted request becomes exactly one memory command,
// its read data or write response is captured, and the winner gets a done pulse.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          err_o,
  output logic                          mem_wr_o,
  output logic                          mem_rd_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  input  logic                          mem_response_i
);

  localparam int               IDX_W    = idx_width(NUM_REQ);
  // Pointer starts on the last requester so requester 0 wins the first arbitration.
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_REQ - 1);

  // Per-requester views of the packed address and data buses.
  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  arb_state_e            state_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      win_q;
  logic                  we_q;
  logic [NUM_REQ-1:0]    gnt_q;
  logic [NUM_REQ-1:0]    done_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  mem_wr_q;
  logic                  mem_rd_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  any_req;
  logic [IDX_W-1:0]      winner;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i     (req_i),
    .rr_ptr_i  (rr_ptr_q),
    .any_req_o (any_req),
    .winner_o  (winner)
  );

  // Transaction FSM: latch the winner's fields at grant, strobe the memory for
  // one cycle, then capture the result and pulse done while back in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= RR_RESET;
      win_q       <= '0;
      we_q        <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Grant and done are single-cycle pulses unless set again below.
      gnt_q  <= '0;
      done_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q       <= winner;
            we_q        <= req_we_i[winner];
            gnt_q       <= NUM_REQ'(1) << winner;
            mem_wr_q    <= req_we_i[winner];
            mem_rd_q    <= ~req_we_i[winner];
            mem_addr_q  <= addr_arr[winner];
            mem_wdata_q <= wdata_arr[winner];
            rr_ptr_q    <= winner;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // Memory samples the command at this edge; address/data keep their values.
          mem_wr_q <= 1'b0;
          mem_rd_q <= 1'b0;
          state_q  <= COMPLETE;
        end
        COMPLETE: begin
          if (we_q) begin
            if (!mem_response_i) begin
              err_q <= 1'b1;
            end
          end else begin
            rdata_q <= mem_rdata_i;
          end
          done_q  <= NUM_REQ'(1) << win_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin controller that shares one synchronous single-port memory (16 x 32, registered write response, registered tri-state read data) between NUM_REQ requesters.
- Arbitrates, issues exactly one memory command per granted request, captures read data or write response, and returns a completion pulse to the winner.
- Sits between requester-side agents (DMA, CPU port, test agents) and the memory's interface signals.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 4, memory address width.
- DATA_WIDTH, 32, memory data width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_we  in  NUM_REQ  1 = write, 0 = read; per requester.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data; requester i uses slice i.
- gnt  out  NUM_REQ  one-hot, 1-cycle grant pulse.
- done  out  NUM_REQ  one-hot, 1-cycle completion pulse.
- rdata  out  DATA_WIDTH  captured read data; valid while done is high for a read.
- err  out  1  sticky; write completed without mem_response.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; Z when the memory is not driving.
- mem_response  in  1  memory write acknowledge, registered by the memory.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, done=0, rdata=0, err=0, mem_wr=0, mem_rd=0, mem_addr=0, mem_wdata=0, state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first).
- FSM states: IDLE -> ISSUE -> COMPLETE -> IDLE.
- IDLE:
  - If any req bit is set at a posedge, pick the winner by round-robin: the first set bit searching upward from rr_ptr+1, wrapping modulo NUM_REQ.
  - Register the winner's index, we, addr and wdata.
  - Drive gnt[winner]=1 and mem_wr=we or mem_rd=!we, with mem_addr/mem_wdata from the winner. Go to ISSUE.
  - Update rr_ptr to the winner.
- ISSUE (one cycle): command is visible to the memory and is sampled at the ending edge. On that edge: gnt=0, mem_wr=0, mem_rd=0, go to COMPLETE. mem_addr/mem_wdata hold their values.
- COMPLETE (one cycle): the memory's read data or response is now valid. On the ending edge:
  - Read: rdata <= mem_rdata.
  - Write: if mem_response==0, set err=1.
  - done[winner]=1 for the following cycle; go to IDLE.
- Latency: req sampled at edge E0 -> gnt in E0..E1 -> done in E2..E3. Throughput is one transaction per 3 cycles.
- The done cycle overlaps IDLE, so a new grant can be issued at the same edge that ends done.
- Request consumption: a request is consumed at its grant. A req still high in IDLE after done is a new request. Requesters hold req_we/req_addr/req_wdata stable until gnt.
- Fields are latched at grant, so changes to a requester's inputs after gnt have no effect.
- mem_wr and mem_rd are never high together; at most one gnt bit and one done bit are set.
- Only the winner's slice is used; simultaneous requests resolve by round-robin. With a single requester asserting continuously, it is granted every 3 cycles.
- rdata holds its last captured value between reads and is not updated on writes.
- err clears only on reset.
- Reset asserted mid-transaction: the transaction is aborted immediately and no done is issued. The memory may already have committed a write sampled before reset.
- Address wrap: none. The address passes through unchanged, full ADDR_WIDTH.

Decomposition:
- Package mem_arb_pkg holds the state enum (IDLE, ISSUE, COMPLETE) and default width constants ADDR_WIDTH_DEF=4, DATA_WIDTH_DEF=32.
- Sub-module rr_picker: combinational. Takes req[NUM_REQ] and rr_ptr; outputs any_req and winner index.
- The FSM, datapath latches and mem_* drive stay in mem_arbiter.

Test Plan:
- Reset low mid-ISSUE (mem_wr=1) -> all outputs 0 immediately, state IDLE, no done pulse. After release, req[1] alone is granted first.
- Requester 0 writes addr=3, wdata=50 -> gnt[0] at +1 cycle, mem_wr=1 addr=3 for exactly 1 cycle, done[0] at +3, err=0. Then requester 0 reads addr=3 -> done[0] with rdata=50.
- req=2'b11 held for 4 transactions (both writes) -> grant order 0,1,0,1. done pulses 3 cycles apart; mem_wr/mem_rd never both high.
- Requester 1 writes 16 addresses 0..15 with data addr*3+1, then reads all 16 back -> every rdata matches; 32 done[1] pulses; err=0.
- Memory model with mem_response forced to 0 on one write -> err rises after that write's COMPLETE and stays 1; subsequent reads still return correct data.
- Requester 0 changes req_addr from 5 to 9 in its gnt cycle -> memory access uses addr 5.
